jtag_dbg_ctrl: RTL and testbench

Debug command sequencer sitting directly upstream of the processor core top. It accepts debug commands from the JTAG transport over a valid/ready channel and converts them into the core's JTAG side-band signals: register read/write, halt flag and PC reset flag. Each command returns exactly one response. Register access is legal only while the core is halted and the halt settle time has elapsed.

---
 rtl/jtag_dbg_ctrl_pkg.sv | 40 ++++
 rtl/jtag_dbg_ctrl_if.sv | 30 +++
 rtl/jtag_dbg_ctrl_cycle_counter.sv | 28 ++
 rtl/jtag_dbg_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_jtag_dbg_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_dbg_ctrl_pkg.sv
// Shared encodings for the JTAG debug command sequencer: op codes, FSM states
// and the register-file width defines reused from the core.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

package jtag_dbg_ctrl_pkg;

    localparam int DBG_OP_W   = 3;
    localparam int DBG_ADDR_W = `REG_ADDR_WIDTH;
    localparam int DBG_DATA_W = `REG_DATA_WIDTH;

    typedef enum logic [DBG_OP_W-1:0] {
        DBG_OP_NOP    = 3'd0,
        DBG_OP_HALT   = 3'd1,
        DBG_OP_RESUME = 3'd2,
        DBG_OP_RESET  = 3'd3,
        DBG_OP_RD_REG = 3'd4,
        DBG_OP_WR_REG = 3'd5
    } dbg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HALT_WAIT = 3'd1,
        ST_REG_RD    = 3'd2,
        ST_REG_WR    = 3'd3,
        ST_RST_PULSE = 3'd4,
        ST_RESP      = 3'd5
    } dbg_state_e;

    // Timed states sit in place while the counter runs N-1 .. 0, so the
    // counter is loaded with one less than the wanted dwell time.
    function automatic int dwell_load(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/jtag_dbg_ctrl_if.sv
// Command/response channel between the JTAG transport (master) and the
// debug sequencer (slave).
interface jtag_dbg_ctrl_if
    import jtag_dbg_ctrl_pkg::*;
#(
    parameter int ADDR_W = `REG_ADDR_WIDTH,
    parameter int DATA_W = `REG_DATA_WIDTH
) ();

    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [DBG_OP_W-1:0] cmd_op_i;
    logic [ADDR_W-1:0]   cmd_addr_i;
    logic [DATA_W-1:0]   cmd_data_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [DATA_W-1:0]   rsp_data_o;
    logic                rsp_err_o;

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

endinterface

// File: rtl/jtag_dbg_ctrl_cycle_counter.sv
// Loadable down-counter with a zero flag; shared by the halt-settle wait and
// the reset pulse of the debug sequencer.
module dbg_cycle_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/jtag_dbg_ctrl.sv
// Debug command sequencer: turns JTAG debug commands into the core's side-band
// register/halt/reset signals. Define JTAG_DBG_WR_VERIFY_EN to read back every write.
module jtag_dbg_ctrl
    import jtag_dbg_ctrl_pkg::*;
#(
    parameter int HALT_SETTLE  = 4,
    parameter int RESET_CYCLES = 2,
    parameter int DATA_W       = `REG_DATA_WIDTH,
    parameter int ADDR_W       = `REG_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    jtag_dbg_ctrl_if.slave    dbg,
    output logic              halted_o,
    output logic [ADDR_W-1:0] jtag_reg_addr_o,
    output logic [DATA_W-1:0] jtag_reg_data_o,
    output logic              jtag_reg_we_o,
    input  logic [DATA_W-1:0] jtag_reg_data_i,
    output logic              jtag_halt_flag_o,
    output logic              jtag_reset_flag_o
);

    localparam int CNT_MAX = (HALT_SETTLE > RESET_CYCLES) ? HALT_SETTLE : RESET_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] HALT_LOAD = CNT_W'(dwell_load(HALT_SETTLE));
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(dwell_load(RESET_CYCLES));

    dbg_state_e        state_reg, state_next;
    logic              cmd_ready_reg, cmd_ready_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
    logic              rsp_err_reg, rsp_err_next;
    logic              halted_reg, halted_next;
    logic              halt_flag_reg, halt_flag_next;
    logic              reset_flag_reg, reset_flag_next;
    logic              reg_we_reg, reg_we_next;
    logic [ADDR_W-1:0] reg_addr_reg, reg_addr_next;
    logic [DATA_W-1:0] reg_data_reg, reg_data_next;
`ifdef JTAG_DBG_WR_VERIFY_EN
    logic              verify_reg, verify_next;
`endif

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero;
    dbg_op_e           op_in;

    assign op_in = dbg_op_e'(dbg.cmd_op_i);

    dbg_cycle_counter #(
        .W(CNT_W)
    ) u_cycle_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_next     = state_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_err_next   = rsp_err_reg;
        halted_next    = halted_reg;
        halt_flag_next = halt_flag_reg;
        reg_addr_next  = reg_addr_reg;
        reg_data_next  = reg_data_reg;
        cnt_load       = 1'b0;
        cnt_load_val   = '0;
        cnt_dec        = 1'b0;
`ifdef JTAG_DBG_WR_VERIFY_EN
        verify_next    = verify_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (dbg.cmd_valid_i) begin
                    // Anything not routed elsewhere answers straight away.
                    state_next    = ST_RESP;
                    rsp_data_next = '0;
                    rsp_err_next  = 1'b0;
                    case (op_in)
                        DBG_OP_NOP: ;
                        DBG_OP_HALT: begin
                            if (!halted_reg) begin
                                halt_flag_next = 1'b1;
                                cnt_load       = 1'b1;
                                cnt_load_val   = HALT_LOAD;
                                state_next     = ST_HALT_WAIT;
                            end
                        end
                        DBG_OP_RESUME: begin
                            halt_flag_next = 1'b0;
                            halted_next    = 1'b0;
                        end
                        DBG_OP_RESET: begin
                            cnt_load     = 1'b1;
                            cnt_load_val = RST_LOAD;
                            state_next   = ST_RST_PULSE;
                        end
                        DBG_OP_RD_REG: begin
                            if (halted_reg) begin
                                reg_addr_next = dbg.cmd_addr_i;
                                state_next    = ST_REG_RD;
`ifdef JTAG_DBG_WR_VERIFY_EN
                                verify_next   = 1'b0;
`endif
                            end else begin
                                rsp_err_next = 1'b1;
                            end
                        end
                        DBG_OP_WR_REG: begin
                            if (halted_reg) begin
                                reg_addr_next = dbg.cmd_addr_i;
                                reg_data_next = dbg.cmd_data_i;
                                state_next    = ST_REG_WR;
`ifdef JTAG_DBG_WR_VERIFY_EN
                                verify_next   = 1'b1;
`endif
                            end else begin
                                rsp_err_next = 1'b1;
                            end
                        end
                        default: rsp_err_next = 1'b1;
                    endcase
                end
            end
            ST_HALT_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    halted_next = 1'b1;
                    state_next  = ST_RESP;
                end
            end
            ST_RST_PULSE: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_next = ST_RESP;
                end
            end
            ST_REG_RD: begin
                rsp_data_next = jtag_reg_data_i;
`ifdef JTAG_DBG_WR_VERIFY_EN
                rsp_err_next  = verify_reg && (jtag_reg_data_i != reg_data_reg);
`endif
                state_next    = ST_RESP;
            end
            ST_REG_WR: begin
`ifdef JTAG_DBG_WR_VERIFY_EN
                state_next = ST_REG_RD;
`else
                state_next = ST_RESP;
`endif
            end
            ST_RESP: begin
                if (dbg.rsp_ready_i) begin
                    rsp_data_next = '0;
                    rsp_err_next  = 1'b0;
                    state_next    = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Strobe-style outputs are registered decodes of the next state.
        cmd_ready_next  = (state_next == ST_IDLE);
        rsp_valid_next  = (state_next == ST_RESP);
        reg_we_next     = (state_next == ST_REG_WR);
        reset_flag_next = (state_next == ST_RST_PULSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cmd_ready_reg  <= 1'b1;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 1'b0;
            halted_reg     <= 1'b0;
            halt_flag_reg  <= 1'b0;
            reset_flag_reg <= 1'b0;
            reg_we_reg     <= 1'b0;
            reg_addr_reg   <= '0;
            reg_data_reg   <= '0;
`ifdef JTAG_DBG_WR_VERIFY_EN
            verify_reg     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cmd_ready_reg  <= cmd_ready_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_err_reg    <= rsp_err_next;
            halted_reg     <= halted_next;
            halt_flag_reg  <= halt_flag_next;
            reset_flag_reg <= reset_flag_next;
            reg_we_reg     <= reg_we_next;
            reg_addr_reg   <= reg_addr_next;
            reg_data_reg   <= reg_data_next;
`ifdef JTAG_DBG_WR_VERIFY_EN
            verify_reg     <= verify_next;
`endif
        end
    end

    assign dbg.cmd_ready_o   = cmd_ready_reg;
    assign dbg.rsp_valid_o   = rsp_valid_reg;
    assign dbg.rsp_data_o    = rsp_data_reg;
    assign dbg.rsp_err_o     = rsp_err_reg;
    assign halted_o          = halted_reg;
    assign jtag_halt_flag_o  = halt_flag_reg;
    assign jtag_reset_flag_o = reset_flag_reg;
    assign jtag_reg_we_o     = reg_we_reg;
    assign jtag_reg_addr_o   = reg_addr_reg;
    assign jtag_reg_data_o   = reg_data_reg;

endmodule

// File: tb/tb_jtag_dbg_ctrl.sv
// Directed bench for jtag_dbg_ctrl: a timeline model predicts each output per
// cycle after a command is accepted; literal latencies/data pin the model.
`timescale 1ns/1ps
module tb_jtag_dbg_ctrl;
    import jtag_dbg_ctrl_pkg::*;

    localparam int HS = 4;
    localparam int RC = 2;
    localparam int DW = 32;
    localparam int AW = 5;
`ifdef JTAG_DBG_WR_VERIFY_EN
    localparam int WR_LAT = 3;
    localparam bit VERIFY = 1'b1;
`else
    localparam int WR_LAT = 2;
    localparam bit VERIFY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtag_dbg_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) dbg_bus ();

    logic          halted, reg_we, halt_flag, reset_flag;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata, reg_rdata;

    jtag_dbg_ctrl #(
        .HALT_SETTLE(HS), .RESET_CYCLES(RC), .DATA_W(DW), .ADDR_W(AW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .dbg               (dbg_bus),
        .halted_o          (halted),
        .jtag_reg_addr_o   (reg_addr),
        .jtag_reg_data_o   (reg_wdata),
        .jtag_reg_we_o     (reg_we),
        .jtag_reg_data_i   (reg_rdata),
        .jtag_halt_flag_o  (halt_flag),
        .jtag_reset_flag_o (reset_flag)
    );

    // Stand-in for the core register file (no x0 suppression here).
    logic [DW-1:0] core_rf [32];
    logic          rf_stuck_zero = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) core_rf[i] <= '0;
        end else if (reg_we) begin
            core_rf[reg_addr] <= reg_wdata;
        end
    end
    assign reg_rdata = rf_stuck_zero ? '0 : core_rf[reg_addr];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: architectural state plus the timeline of the command in flight.
    bit            chk_en = 1'b0;
    bit            inflight = 1'b0;
    int            acc_cyc, e_lat, e_we_k, e_rd_k, e_rst_to, e_halted_from;
    logic          e_flag_pre, e_flag_post, e_halted_pre, e_halted_post, e_err;
    logic [DW-1:0] e_data, e_wdata;
    logic [AW-1:0] e_addr;
    logic          m_flag = 1'b0;
    logic          m_halted = 1'b0;
    logic [DW-1:0] m_rf [32];
    int            rst_hi_cnt = 0;
    int            we_cnt = 0;
    int            c_k;
    logic          c_flag, c_halted;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (reset_flag) rst_hi_cnt++;
            if (reg_we) we_cnt++;
            if (!inflight) begin
                chk("idle_cmd_ready", dbg_bus.cmd_ready_o, 1'b1);
                chk("idle_rsp_valid", dbg_bus.rsp_valid_o, 1'b0);
                chk("idle_reg_we", reg_we, 1'b0);
                chk("idle_reset_flag", reset_flag, 1'b0);
                chk("idle_halt_flag", halt_flag, m_flag);
                chk("idle_halted", halted, m_halted);
            end else begin
                c_k      = cyc - acc_cyc + 1;
                c_flag   = (c_k >= 1) ? e_flag_post : e_flag_pre;
                c_halted = (c_k >= e_halted_from) ? e_halted_post : e_halted_pre;
                chk("busy_cmd_ready", dbg_bus.cmd_ready_o, 1'b0);
                chk("rsp_valid", dbg_bus.rsp_valid_o, c_k >= e_lat);
                chk("reg_we", reg_we, c_k == e_we_k);
                chk("reset_flag", reset_flag, (c_k >= 1) && (c_k <= e_rst_to));
                chk("halt_flag", halt_flag, c_flag);
                chk("halted", halted, c_halted);
                if (c_k == e_we_k) begin
                    chk("wr_addr", reg_addr, e_addr);
                    chk("wr_data", reg_wdata, e_wdata);
                end
                if (c_k == e_rd_k) chk("rd_addr", reg_addr, e_addr);
                if (c_k >= e_lat) begin
                    chk("rsp_data", dbg_bus.rsp_data_o, e_data);
                    chk("rsp_err", dbg_bus.rsp_err_o, e_err);
                end
            end
        end
    end

    task automatic predict(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        e_lat = 1; e_we_k = -1; e_rd_k = -1; e_rst_to = 0; e_halted_from = 1;
        e_flag_pre = m_flag; e_flag_post = m_flag;
        e_halted_pre = m_halted; e_halted_post = m_halted;
        e_data = '0; e_err = 1'b0; e_addr = addr; e_wdata = data;
        case (op)
            3'd0: ;
            3'd1: if (!m_halted) begin
                e_lat = HS + 1; e_flag_post = 1'b1; e_halted_post = 1'b1; e_halted_from = HS + 1;
            end
            3'd2: begin e_flag_post = 1'b0; e_halted_post = 1'b0; end
            3'd3: begin e_lat = RC + 1; e_rst_to = RC; end
            3'd4: if (!m_halted) e_err = 1'b1;
                  else begin e_lat = 2; e_rd_k = 1; e_data = rf_stuck_zero ? '0 : m_rf[addr]; end
            3'd5: if (!m_halted) e_err = 1'b1;
                  else begin
                      e_we_k = 1; e_lat = WR_LAT; m_rf[addr] = data;
                      if (VERIFY) begin
                          e_rd_k = 2; e_data = rf_stuck_zero ? '0 : data; e_err = (e_data != data);
                      end
                  end
            default: e_err = 1'b1;
        endcase
    endtask

    task automatic finish_now();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(negedge clk);
        predict(op, addr, data);
        dbg_bus.cmd_valid_i = 1'b1;
        dbg_bus.cmd_op_i    = op;
        dbg_bus.cmd_addr_i  = addr;
        dbg_bus.cmd_data_i  = data;
        @(posedge clk);
        #1;
        dbg_bus.cmd_valid_i = 1'b0;
        acc_cyc  = cyc;
        inflight = 1'b1;
    endtask

    task automatic run(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input int hold, input int lit_lat, input logic lit_err, input logic [DW-1:0] lit_data);
        int  lat;
        bit  got;
        issue(op, addr, data);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (dbg_bus.rsp_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            finish_now();
        end
        chk("lit_latency", lat, lit_lat);
        chk("lit_err", dbg_bus.rsp_err_o, lit_err);
        chk("lit_data", dbg_bus.rsp_data_o, lit_data);
        repeat (hold) @(negedge clk);
        dbg_bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        dbg_bus.rsp_ready_i = 1'b0;
        m_flag   = e_flag_post;
        m_halted = e_halted_post;
        inflight = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        dbg_bus.cmd_valid_i = 1'b0;
        dbg_bus.cmd_op_i    = '0;
        dbg_bus.cmd_addr_i  = '0;
        dbg_bus.cmd_data_i  = '0;
        dbg_bus.rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_cmd_ready", dbg_bus.cmd_ready_o, 1'b1);
        chk("rst_rsp_valid", dbg_bus.rsp_valid_o, 1'b0);
        chk("rst_rsp_data", dbg_bus.rsp_data_o, 32'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_halt_flag", halt_flag, 1'b0);
        chk("rst_reset_flag", reset_flag, 1'b0);
        chk("rst_reg_outs", {reg_we, reg_addr, reg_wdata[7:0]}, 32'h0);
        chk_en = 1'b1;

        run(3'd4, 5'd5, 32'h0, 0, 1, 1'b1, 32'h0);               // RD while running
        chk("no_we_running", we_cnt, 0);
        run(3'd1, 5'd0, 32'h0, 0, 5, 1'b0, 32'h0);               // HALT
        chk("halted_after_halt", halted, 1'b1);
        we_cnt = 0;
        run(3'd5, 5'd3, 32'hDEADBEEF, 0, WR_LAT, 1'b0, VERIFY ? 32'hDEADBEEF : 32'h0);
        chk("one_we_pulse", we_cnt, 1);
        run(3'd4, 5'd3, 32'h0, 10, 2, 1'b0, 32'hDEADBEEF);       // RD with held response
        run(3'd5, 5'd0, 32'h12345678, 0, WR_LAT, 1'b0, VERIFY ? 32'h12345678 : 32'h0);
        run(3'd4, 5'd0, 32'h0, 2, 2, 1'b0, 32'h12345678);
        rst_hi_cnt = 0;
        run(3'd3, 5'd0, 32'h0, 0, 3, 1'b0, 32'h0);               // RESET pulse
        chk("reset_pulse_len", rst_hi_cnt, 2);
        chk("halt_kept_by_reset", halted, 1'b1);
        run(3'd7, 5'd1, 32'h0, 0, 1, 1'b1, 32'h0);
        run(3'd6, 5'd1, 32'h0, 0, 1, 1'b1, 32'h0);
        run(3'd0, 5'd0, 32'h0, 0, 1, 1'b0, 32'h0);
        run(3'd1, 5'd0, 32'h0, 0, 1, 1'b0, 32'h0);               // HALT while halted
        rf_stuck_zero = 1'b1;
        run(3'd5, 5'd7, 32'hA5A5A5A5, 0, WR_LAT, VERIFY, 32'h0);
        rf_stuck_zero = 1'b0;
        run(3'd2, 5'd0, 32'h0, 0, 1, 1'b0, 32'h0);               // RESUME
        chk("resume_halted", halted, 1'b0);
        chk("resume_flag", halt_flag, 1'b0);
        we_cnt = 0;
        run(3'd5, 5'd2, 32'h55, 0, 1, 1'b1, 32'h0);              // WR while running
        chk("no_we_after_resume", we_cnt, 0);

        // rst in the middle of a halt settle wait
        issue(3'd1, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        inflight = 1'b0;
        m_flag   = 1'b0;
        m_halted = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_halt_flag", halt_flag, 1'b0);
        chk("midrst_rsp_valid", dbg_bus.rsp_valid_o, 1'b0);
        chk("midrst_cmd_ready", dbg_bus.cmd_ready_o, 1'b1);
        repeat (3) @(negedge clk);
        run(3'd0, 5'd0, 32'h0, 0, 1, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        finish_now();
    end

endmodule
